// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Contents:
//   fwd_sel_t   - execute-stage operand source select (regfile / writeback / memory)
//   REG_X0      - index of the hard-wired zero register
//   reg_onehot  - one-hot decode of a 5-bit register index
//   fwd_select  - forwarding priority rule shared by both execute operands
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  // One-hot decode of a register index into the 32-entry register space.
  function automatic logic [31:0] reg_onehot(input logic [4:0] idx);
    reg_onehot = 32'd1 << idx;
  endfunction

  // The memory stage holds the younger result, so it wins over writeback.
  // x0 is never forwarded because its value is constant.
  function automatic fwd_sel_t fwd_select(input logic [4:0] src,
                                          input logic       mem_we,
                                          input logic [4:0] mem_rd,
                                          input logic       wb_we,
                                          input logic [4:0] wb_rd);
    if (mem_we && (mem_rd != REG_X0) && (mem_rd == src)) begin
      return FWD_MEM;
    end else if (wb_we && (wb_rd != REG_X0) && (wb_rd == src)) begin
      return FWD_WB;
    end else begin
      return FWD_RF;
    end
  endfunction

endpackage

// File: rtl/hazard_scoreboard_regs.sv
// Scoreboard state for in-flight long-latency (mul/div) operations.
// Ports:
//   clk, reset       - core clock, asynchronous active-low reset
//   issue, issue_rd  - a long op leaves decode this cycle and will write issue_rd
//   lw_valid, lw_rd  - a long op completes this cycle for register lw_rd
//   pending          - bit i set while register i awaits a long-op result
//   count            - number of long ops currently in flight
//   retire           - the completion this cycle matches a pending register
//   sb_error         - sticky flag: a completion arrived for a non-pending register
module scoreboard_regs
  import hazard_scoreboard_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue,
  input  logic [4:0]       issue_rd,
  input  logic             lw_valid,
  input  logic [4:0]       lw_rd,
  output logic [31:0]      pending,
  output logic [CNT_W-1:0] count,
  output logic             retire,
  output logic             sb_error
);

  logic [31:0]      clr_vec;
  logic [31:0]      set_vec;
  logic [31:0]      pending_next;
  logic [CNT_W-1:0] count_next;

  // A completion only retires something if its register is actually pending;
  // anything else is a protocol error and must leave the state untouched.
  always_comb begin
    retire       = lw_valid && (lw_rd != REG_X0) && pending[lw_rd];
    clr_vec      = retire ? reg_onehot(lw_rd) : '0;
    set_vec      = issue ? reg_onehot(issue_rd) : '0;
    // Set is applied after clear so a register re-issued in its completion
    // cycle stays pending; x0 is masked so it can never become pending.
    pending_next = ((pending & ~clr_vec) | set_vec) & ~reg_onehot(REG_X0);
    // The top level blocks issue while full, so this never overflows, and
    // retire implies a pending bit and therefore count >= 1.
    count_next   = count + CNT_W'(issue) - CNT_W'(retire);
  end

  // Pending vector, occupancy counter and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending  <= '0;
      count    <= '0;
      sb_error <= 1'b0;
    end else begin
      pending <= pending_next;
      count   <= count_next;
      if (lw_valid && !retire) begin
        sb_error <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard controller for the 5-stage core.
// Combines scoreboard (long-latency RAW/WAW), outstanding-limit and load-use
// hazards into fetch/decode stall and decode/execute flush controls, and
// produces the execute-stage operand forwarding selects.
// Ports:
//   clk, reset                    - core clock, asynchronous active-low reset
//   d_*                           - decode-stage instruction fields
//   e_rs1/e_rs2/e_rd, e_is_load   - execute-stage fields
//   e_pc_src                      - taken branch/jump resolved in execute
//   m_rd/m_reg_write, w_rd/w_reg_write - memory / writeback destinations
//   lw_valid, lw_rd               - long-latency op completion
//   f_stall, d_stall              - hold fetch PC / decode register
//   d_flush, e_flush              - clear decode / execute register
//   fwd_a, fwd_b                  - execute operand sources (00 rf, 10 mem, 01 wb)
//   pending                       - scoreboard bit per register
//   sb_error                      - sticky completion-without-pending flag
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_valid,
  input  logic [4:0]  d_rs1,
  input  logic [4:0]  d_rs2,
  input  logic [4:0]  d_rd,
  input  logic        d_uses_rs1,
  input  logic        d_uses_rs2,
  input  logic        d_reg_write,
  input  logic        d_long,
  input  logic [4:0]  e_rs1,
  input  logic [4:0]  e_rs2,
  input  logic [4:0]  e_rd,
  input  logic        e_is_load,
  input  logic        e_pc_src,
  input  logic [4:0]  m_rd,
  input  logic [4:0]  w_rd,
  input  logic        m_reg_write,
  input  logic        w_reg_write,
  input  logic        lw_valid,
  input  logic [4:0]  lw_rd,
  output logic        f_stall,
  output logic        d_stall,
  output logic        d_flush,
  output logic        e_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [31:0] pending,
  output logic        sb_error
);

  localparam logic [CNT_W:0] MAX_CNT = (CNT_W + 1)'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] count;
  logic             retire;
  logic             issue;
  logic [31:0]      eff_pending;
  logic [CNT_W:0]   live_count;
  logic             sb_hazard;
  logic             cnt_full;
  logic             lu_stall;
  logic             stall;
  fwd_sel_t         fwd_a_sel;
  fwd_sel_t         fwd_b_sel;

  scoreboard_regs #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_regs (
    .clk      (clk),
    .reset    (reset),
    .issue    (issue),
    .issue_rd (d_rd),
    .lw_valid (lw_valid),
    .lw_rd    (lw_rd),
    .pending  (pending),
    .count    (count),
    .retire   (retire),
    .sb_error (sb_error)
  );

  // Hazard detection. A register completing this cycle counts as ready
  // because the regfile writes in the first half and reads in the second.
  // x0 never has its pending bit set, so reads/writes of x0 never hazard.
  always_comb begin
    eff_pending = pending & ~(lw_valid ? reg_onehot(lw_rd) : 32'd0);

    sb_hazard = d_valid &&
                ((d_uses_rs1  && eff_pending[d_rs1]) ||
                 (d_uses_rs2  && eff_pending[d_rs2]) ||
                 (d_reg_write && eff_pending[d_rd]));

    // A slot freed by this cycle's completion is immediately reusable.
    live_count = {1'b0, count} - (CNT_W + 1)'(retire);
    cnt_full   = d_valid && d_long && (live_count >= MAX_CNT);

    lu_stall = e_is_load && (e_rd != REG_X0) &&
               ((d_uses_rs1 && (d_rs1 == e_rd)) ||
                (d_uses_rs2 && (d_rs2 == e_rd)));

    // A taken branch discards the decode instruction, so stalling it is moot.
    stall = (sb_hazard || cnt_full || lu_stall) && !e_pc_src;

    issue = d_valid && d_long && d_reg_write && (d_rd != REG_X0) &&
            !stall && !e_pc_src;
  end

  // Operand forwarding for the instruction currently in execute.
  always_comb begin
    fwd_a_sel = fwd_select(e_rs1, m_reg_write, m_rd, w_reg_write, w_rd);
    fwd_b_sel = fwd_select(e_rs2, m_reg_write, m_rd, w_reg_write, w_rd);
  end

  // Pipeline controls are held inactive while reset is asserted so the
  // stages see a quiet pipeline regardless of stray inputs.
  always_comb begin
    f_stall = reset && stall;
    d_stall = reset && stall;
    d_flush = reset && e_pc_src;
    e_flush = reset && (stall || e_pc_src);
    fwd_a   = reset ? fwd_a_sel : FWD_RF;
    fwd_b   = reset ? fwd_b_sel : FWD_RF;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard.
// A queue of in-flight destination registers stands in for the scoreboard;
// every cycle the expected outputs are derived from it and the current
// inputs, and the queue is updated at the clock edge.
module tb_hazard_scoreboard;

  localparam int MAX_OUT = 4;

  logic        clk;
  logic        reset;
  logic        d_valid;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic        d_uses_rs1, d_uses_rs2, d_reg_write, d_long;
  logic [4:0]  e_rs1, e_rs2, e_rd;
  logic        e_is_load, e_pc_src;
  logic [4:0]  m_rd, w_rd;
  logic        m_reg_write, w_reg_write;
  logic        lw_valid;
  logic [4:0]  lw_rd;
  logic        f_stall, d_stall, d_flush, e_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] pending;
  logic        sb_error;

  int checks = 0;
  int errors = 0;

  // Reference model state: registers awaiting a long-op result, and the
  // sticky error flag.
  int inflight[$];
  bit err_m;

  logic [40:0] exp_v;
  logic [40:0] got_v;

  hazard_scoreboard #(.MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .d_valid     (d_valid),
    .d_rs1       (d_rs1),
    .d_rs2       (d_rs2),
    .d_rd        (d_rd),
    .d_uses_rs1  (d_uses_rs1),
    .d_uses_rs2  (d_uses_rs2),
    .d_reg_write (d_reg_write),
    .d_long      (d_long),
    .e_rs1       (e_rs1),
    .e_rs2       (e_rs2),
    .e_rd        (e_rd),
    .e_is_load   (e_is_load),
    .e_pc_src    (e_pc_src),
    .m_rd        (m_rd),
    .w_rd        (w_rd),
    .m_reg_write (m_reg_write),
    .w_reg_write (w_reg_write),
    .lw_valid    (lw_valid),
    .lw_rd       (lw_rd),
    .f_stall     (f_stall),
    .d_stall     (d_stall),
    .d_flush     (d_flush),
    .e_flush     (e_flush),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .pending     (pending),
    .sb_error    (sb_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_pending(input logic [4:0] r);
    foreach (inflight[i]) if (inflight[i] == int'(r)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_pending_vec();
    logic [31:0] v = '0;
    foreach (inflight[i]) v[inflight[i]] = 1'b1;
    return v;
  endfunction

  // Register still unavailable to decode after this cycle's completion.
  function automatic bit m_busy(input logic [4:0] r);
    return m_pending(r) && !(lw_valid && lw_rd == r);
  endfunction

  function automatic bit m_stall();
    bit sb, full, lu;
    int live;
    sb = d_valid && ((d_uses_rs1 && m_busy(d_rs1)) ||
                     (d_uses_rs2 && m_busy(d_rs2)) ||
                     (d_reg_write && m_busy(d_rd)));
    live = inflight.size() - ((lw_valid && m_pending(lw_rd)) ? 1 : 0);
    full = d_valid && d_long && (live >= MAX_OUT);
    lu = e_is_load && e_rd != 0 &&
         ((d_uses_rs1 && d_rs1 == e_rd) || (d_uses_rs2 && d_rs2 == e_rd));
    return (sb || full || lu) && !e_pc_src;
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (m_reg_write && m_rd != 0 && m_rd == src) return 2'b10;
    if (w_reg_write && w_rd != 0 && w_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  // Packed order: f_stall, d_stall, d_flush, e_flush, fwd_a, fwd_b, sb_error, pending
  function automatic logic [40:0] expected_outputs();
    bit st;
    if (!reset) return {8'b0, err_m, m_pending_vec()};
    st = m_stall();
    return {st, st, e_pc_src, st || e_pc_src, m_fwd(e_rs1), m_fwd(e_rs2),
            err_m, m_pending_vec()};
  endfunction

  function automatic logic [40:0] observed();
    return {f_stall, d_stall, d_flush, e_flush, fwd_a, fwd_b, sb_error, pending};
  endfunction

  task automatic model_reset();
    inflight.delete();
    err_m = 1'b0;
  endtask

  // Clock-edge update of the model from the inputs present at the edge.
  task automatic model_commit();
    bit st, iss;
    if (!reset) begin
      model_reset();
      return;
    end
    st  = m_stall();
    iss = d_valid && d_long && d_reg_write && d_rd != 0 && !st && !e_pc_src;
    if (lw_valid) begin
      if (lw_rd != 0 && m_pending(lw_rd)) begin
        foreach (inflight[i]) begin
          if (inflight[i] == int'(lw_rd)) begin
            inflight.delete(i);
            break;
          end
        end
      end else begin
        err_m = 1'b1;
      end
    end
    if (iss) inflight.push_back(int'(d_rd));
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic set_idle();
    d_valid = 0; d_rs1 = 0; d_rs2 = 0; d_rd = 0;
    d_uses_rs1 = 0; d_uses_rs2 = 0; d_reg_write = 0; d_long = 0;
    e_rs1 = 0; e_rs2 = 0; e_rd = 0; e_is_load = 0; e_pc_src = 0;
    m_rd = 0; w_rd = 0; m_reg_write = 0; w_reg_write = 0;
    lw_valid = 0; lw_rd = 0;
  endtask

  task automatic set_long(input logic [4:0] rd);
    set_idle();
    d_valid = 1; d_long = 1; d_reg_write = 1; d_rd = rd;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b0;
    model_reset();
    #2;
    exp_v = expected_outputs(); got_v = observed(); checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("[TB] FAIL reset_idle: observed %h required %h", got_v, exp_v);
    end
    // Load-use and branch inputs must not leak through while reset is held.
    e_is_load = 1; e_rd = 7; d_uses_rs1 = 1; d_rs1 = 7; e_pc_src = 1;
    m_reg_write = 1; m_rd = 3; e_rs1 = 3;
    #1;
    exp_v = expected_outputs(); got_v = observed(); checks++;
    if (got_v !== 41'd0) begin
      errors++;
      $display("[TB] FAIL reset_forced_zero: observed %h required %h", got_v, 41'd0);
    end
    set_idle();
    @(negedge clk);
    reset = 1'b1;
    applyStimulus();
  endtask

  task automatic test_div_raw();
    set_long(5);
    @(negedge clk);
    exp_v = expected_outputs(); got_v = observed(); checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("[TB] FAIL div_issue: observed %h required %h", got_v, exp_v);
    end
    applyStimulus();
    // ADD x6, x5, x1 waits on the divide
    set_idle();
    d_valid = 1; d_uses_rs1 = 1; d_uses_rs2 = 1; d_rs1 = 5; d_rs2 = 1;
    d_reg_write = 1; d_rd = 6;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin lw_valid = 1; lw_rd = 5; end
      @(negedge clk);
      exp_v = expected_outputs(); got_v = observed(); checks++;
      if (got_v !== exp_v || (i < 3 && d_stall !== 1'b1) || (i == 3 && d_stall !== 1'b0)) begin
        errors++;
        $display("[TB] FAIL div_raw cycle %0d: observed %h required %h", i, got_v, exp_v);
      end
      applyStimulus();
    end
    set_idle();
    @(negedge clk);
    exp_v = expected_outputs(); got_v = observed(); checks++;
    if (got_v !== exp_v || pending[5] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL div_retired: observed %h required %h", got_v, exp_v);
    end
    applyStimulus();
  endtask

  task automatic test_load_use();
    for (int i = 0; i < 3; i++) begin
      set_idle();
      d_valid = 1; d_uses_rs2 = 1; d_reg_write = 1; d_rd = 8;
      case (i)
        0: begin e_is_load = 1; e_rd = 7; d_rs2 = 7; end
        1: begin e_is_load = 0; e_rd = 0; d_rs2 = 7; end
        default: begin e_is_load = 1; e_rd = 0; d_rs2 = 0; end
      endcase
      @(negedge clk);
      exp_v = expected_outputs(); got_v = observed(); checks++;
      if (got_v !== exp_v || e_flush !== (i == 0)) begin
        errors++;
        $display("[TB] FAIL load_use step %0d: observed %h required %h", i, got_v, exp_v);
      end
      applyStimulus();
    end
  endtask

  task automatic test_max_outstanding();
    for (int r = 1; r <= 6; r++) begin
      set_long(r <= 4 ? 5'(r) : 5'd8);
      if (r == 6) begin lw_valid = 1; lw_rd = 1; end
      @(negedge clk);
      exp_v = expected_outputs(); got_v = observed(); checks++;
      if (got_v !== exp_v || (r == 5 && d_stall !== 1'b1)) begin
        errors++;
        $display("[TB] FAIL max_outstanding step %0d: observed %h required %h", r, got_v, exp_v);
      end
      applyStimulus();
    end
    // drain everything that is still outstanding
    while (inflight.size() > 0) begin
      set_idle();
      lw_valid = 1; lw_rd = 5'(inflight[0]);
      @(negedge clk);
      exp_v = expected_outputs(); got_v = observed(); checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL drain x%0d: observed %h required %h", lw_rd, got_v, exp_v);
      end
      applyStimulus();
    end
  endtask

  task automatic test_branch_override();
    set_long(5);
    applyStimulus();
    set_idle();
    d_valid = 1; d_uses_rs1 = 1; d_rs1 = 5; d_reg_write = 1; d_rd = 6;
    e_pc_src = 1;
    @(negedge clk);
    exp_v = expected_outputs(); got_v = observed(); checks++;
    if (got_v !== exp_v || d_stall !== 1'b0 || d_flush !== 1'b1) begin
      errors++;
      $display("[TB] FAIL branch_override: observed %h required %h", got_v, exp_v);
    end
    applyStimulus();
    set_idle();
    lw_valid = 1; lw_rd = 5;
    @(negedge clk);
    exp_v = expected_outputs(); got_v = observed(); checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("[TB] FAIL branch_cleanup: observed %h required %h", got_v, exp_v);
    end
    applyStimulus();
  endtask

  task automatic test_forwarding();
    for (int i = 0; i < 5; i++) begin
      set_idle();
      m_rd = 9; w_rd = 9; m_reg_write = 1; w_reg_write = 1; e_rs1 = 9;
      case (i)
        1: m_reg_write = 0;
        2: e_rs1 = 0;
        3: begin e_rs2 = 9; w_rd = 4; e_rs1 = 4; end
        4: begin m_rd = 0; w_rd = 0; end
        default: ;
      endcase
      @(negedge clk);
      exp_v = expected_outputs(); got_v = observed(); checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL forwarding pattern %0d: observed %h required %h", i, got_v, exp_v);
      end
      applyStimulus();
    end
  endtask

  task automatic test_sb_error();
    set_idle();
    lw_valid = 1; lw_rd = 12;
    applyStimulus();
    for (int i = 0; i < 2; i++) begin
      set_idle();
      @(negedge clk);
      exp_v = expected_outputs(); got_v = observed(); checks++;
      if (got_v !== exp_v || sb_error !== 1'b1) begin
        errors++;
        $display("[TB] FAIL sb_error_sticky %0d: observed %h required %h", i, got_v, exp_v);
      end
      applyStimulus();
    end
  endtask

  task automatic test_async_reset();
    for (int r = 10; r <= 12; r++) begin
      set_long(5'(r));
      applyStimulus();
    end
    set_idle();
    d_valid = 1; d_uses_rs1 = 1; d_rs1 = 10; e_pc_src = 1;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    exp_v = expected_outputs(); got_v = observed(); checks++;
    if (got_v !== exp_v || got_v !== 41'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: observed %h required %h", got_v, exp_v);
    end
    set_idle();
    @(negedge clk);
    reset = 1'b1;
    applyStimulus();
    lw_valid = 1; lw_rd = 11;
    applyStimulus();
    set_idle();
    @(negedge clk);
    exp_v = expected_outputs(); got_v = observed(); checks++;
    if (got_v !== exp_v || sb_error !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stale_completion: observed %h required %h", got_v, exp_v);
    end
    applyStimulus();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      d_valid     = ($urandom_range(0, 9) < 8);
      d_rs1       = 5'($urandom_range(0, 7));
      d_rs2       = 5'($urandom_range(0, 7));
      d_rd        = 5'($urandom_range(0, 7));
      d_uses_rs1  = 1'($urandom);
      d_uses_rs2  = 1'($urandom);
      d_reg_write = ($urandom_range(0, 9) < 8);
      d_long      = ($urandom_range(0, 9) < 3);
      e_rs1       = 5'($urandom_range(0, 7));
      e_rs2       = 5'($urandom_range(0, 7));
      e_rd        = 5'($urandom_range(0, 7));
      e_is_load   = ($urandom_range(0, 9) < 3);
      e_pc_src    = ($urandom_range(0, 9) < 1);
      m_rd        = 5'($urandom_range(0, 7));
      w_rd        = 5'($urandom_range(0, 7));
      m_reg_write = 1'($urandom);
      w_reg_write = 1'($urandom);
      lw_valid    = ($urandom_range(0, 9) < 3);
      if (inflight.size() > 0 && $urandom_range(0, 19) != 0)
        lw_rd = 5'(inflight[$urandom_range(0, inflight.size() - 1)]);
      else
        lw_rd = 5'($urandom_range(0, 31));
      @(negedge clk);
      exp_v = expected_outputs(); got_v = observed(); checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: observed %h required %h", n, got_v, exp_v);
      end
      applyStimulus();
    end
  endtask

  initial begin
    reset = 1'b0;
    set_idle();
    test_reset();
    test_div_raw();
    test_load_use();
    test_max_outstanding();
    test_branch_override();
    test_forwarding();
    test_sb_error();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
